// File: rtl/fp_div_seq.sv
// IEEE-754 single-precision sequential divider: radix-2 restoring mantissa division,
// truncation rounding, denormals flushed to zero, valid/ready handshake on both sides.
module fp_div_seq #(
  parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIVIDE = 2'd1;
  localparam logic [1:0] ST_NORM   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  function automatic logic [1:0] fp_class(input logic [31:0] v);
    logic [1:0] cls;
    case (v[30:23])
      8'd0:    cls = CLS_ZERO;
      8'd255:  cls = (v[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
      default: cls = CLS_NORM;
    endcase
    return cls;
  endfunction

  logic [1:0]        state_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [31:0]       result_r;
  logic [3:0]        flags_r;
  logic              sign_r;
  logic signed [9:0] exp_diff_r;
  logic [24:0]       rem_r;
  logic [23:0]       div_r;
  logic [24:0]       q_r;
  logic [4:0]        cnt_r;

  logic [1:0]        cls_a_s;
  logic [1:0]        cls_b_s;
  logic              sign_in_s;
  logic              special_s;
  logic [31:0]       spec_result_s;
  logic [3:0]        spec_flags_s;
  logic              q_bit_s;
  logic [24:0]       rem_sub_s;
  logic [24:0]       rem_next_s;
  logic signed [9:0] exp_in_s;
  logic signed [9:0] exp_norm_s;
  logic [22:0]       man_norm_s;
  logic [31:0]       norm_result_s;
  logic [3:0]        norm_flags_s;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign flags     = flags_r;

  assign cls_a_s   = fp_class(dataA);
  assign cls_b_s   = fp_class(dataB);
  assign sign_in_s = dataA[31] ^ dataB[31];
  assign exp_in_s  = $signed({2'b00, dataA[30:23]}) - $signed({2'b00, dataB[30:23]});

  // Special-operand classification; inf/0 yields inf without div_by_zero
  always_comb begin
    special_s     = 1'b1;
    spec_result_s = 32'd0;
    spec_flags_s  = 4'd0;
    if (cls_a_s == CLS_NAN || cls_b_s == CLS_NAN ||
        (cls_a_s == CLS_ZERO && cls_b_s == CLS_ZERO) ||
        (cls_a_s == CLS_INF && cls_b_s == CLS_INF)) begin
      spec_result_s = NAN_VALUE;
      spec_flags_s  = 4'b1000;
    end else if (cls_a_s == CLS_INF) begin
      spec_result_s = {sign_in_s, 8'hFF, 23'd0};
    end else if (cls_b_s == CLS_ZERO) begin
      spec_result_s = {sign_in_s, 8'hFF, 23'd0};
      spec_flags_s  = 4'b0100;
    end else if (cls_a_s == CLS_ZERO || cls_b_s == CLS_INF) begin
      spec_result_s = {sign_in_s, 31'd0};
    end else begin
      special_s = 1'b0;
    end
  end

  // One restoring step: partial remainder stays below twice the divisor
  always_comb begin
    q_bit_s    = (rem_r >= {1'b0, div_r});
    rem_sub_s  = rem_r - {1'b0, div_r};
    rem_next_s = q_bit_s ? rem_sub_s : rem_r;
  end

  // Normalisation and exponent range check on the finished quotient
  always_comb begin
    exp_norm_s = exp_diff_r + (q_r[24] ? 10'sd127 : 10'sd126);
    man_norm_s = q_r[24] ? q_r[23:1] : q_r[22:0];
    if (exp_norm_s >= 10'sd255) begin
      norm_result_s = {sign_r, 8'hFF, 23'd0};
      norm_flags_s  = 4'b0010;
    end else if (exp_norm_s <= 10'sd0) begin
      norm_result_s = {sign_r, 31'd0};
      norm_flags_s  = 4'b0001;
    end else begin
      norm_result_s = {sign_r, exp_norm_s[7:0], man_norm_s};
      norm_flags_s  = 4'b0000;
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= 32'd0;
      flags_r     <= 4'd0;
      sign_r      <= 1'b0;
      exp_diff_r  <= 10'sd0;
      rem_r       <= 25'd0;
      div_r       <= 24'd0;
      q_r         <= 25'd0;
      cnt_r       <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            sign_r     <= sign_in_s;
            if (special_s) begin
              result_r    <= spec_result_s;
              flags_r     <= spec_flags_s;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              exp_diff_r <= exp_in_s;
              rem_r      <= {2'b01, dataA[22:0]};
              div_r      <= {1'b1, dataB[22:0]};
              q_r        <= 25'd0;
              cnt_r      <= 5'd0;
              state_r    <= ST_DIVIDE;
            end
          end
        end
        ST_DIVIDE: begin
          q_r   <= {q_r[23:0], q_bit_s};
          rem_r <= rem_next_s << 1;
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd24) begin
            state_r <= ST_NORM;
          end
        end
        ST_NORM: begin
          result_r    <= norm_result_s;
          flags_r     <= norm_flags_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: vector table through a scoreboard queue,
// plus hand-written back-pressure and mid-divide reset sequences.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dataA = 32'd0;
  logic [31:0] dataB = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [3:0]  flags;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  fp_div_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic collect(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: output with empty scoreboard, got %h", name, result);
    end else begin
      e = sb_q.pop_front();
      check({name, " result"}, result, e.res);
      check({name, " flags"}, {28'd0, flags}, {28'd0, e.flg});
    end
  endtask

  // Issue one op and return just after accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input string name);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    dataA = a;
    dataB = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dataA = $urandom;
    dataB = $urandom;
  endtask

  // Wait for out_valid; latency counts edges from accept to the handshake edge
  task automatic wait_out(input int exp_lat, input string name);
    int lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat + 1, exp_lat);
    if (out_valid) collect(name);
    else if (sb_q.size() != 0) e = sb_q.pop_front();
  endtask

  task automatic run_op(input vec_t v, input string name);
    issue(v.a, v.b, name);
    sb_q.push_back('{v.res, v.flg});
    wait_out(v.lat, name);
    @(posedge clk); #1;
  endtask

  initial begin
    int bad;
    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27});
    vecs.push_back('{32'h40A00000, 32'h00000000, 32'h7F800000, 4'b0100, 1});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'hC0000000, 32'h7F800000, 32'h80000000, 4'b0000, 1});
    vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27});
    vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27});
    vecs.push_back('{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'hFF800000, 32'h00000000, 32'hFF800000, 4'b0000, 1});
    vecs.push_back('{32'h3F000000, 32'hC0000000, 32'hBE800000, 4'b0000, 27});
    vecs.push_back('{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, 27});
    vecs.push_back('{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 1});
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1});
    vecs.push_back('{32'h3F800000, 32'h7F800001, 32'h7FC00000, 4'b1000, 1});
    vecs.push_back('{32'h3F800000, 32'h3FFFFFFF, 32'h3F000000, 4'b0000, 27});
    vecs.push_back('{32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 27});
    vecs.push_back('{32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0010, 27});
    vecs.push_back('{32'h00800000, 32'h3FC00000, 32'h00000000, 4'b0001, 27});

    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", {28'd0, flags}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: result held while out_ready is low
    out_ready = 1'b0;
    issue(32'h40C00000, 32'h40000000, "hold");
    sb_q.push_back('{32'h40400000, 4'b0000});
    wait_out(27, "hold");
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (result !== 32'h40400000 || flags !== 4'd0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    check("hold stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold release out_valid", {31'd0, out_valid}, 32'd0);
    check("hold release in_ready", {31'd0, in_ready}, 32'd1);
    run_op(vecs[1], "back_to_back");

    // Reset in the middle of a divide aborts it
    issue(32'h40C00000, 32'h40000000, "abort");
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'd0, out_valid}, 32'd0);
    check("abort result", result, 32'd0);
    check("abort flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", {31'd0, in_ready}, 32'd1);
    run_op(vecs[0], "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
